// File: rtl/i2c_reg_bank_pkg.sv
// i2c_reg_bank_pkg: state encoding, sizing helper and default register map for the I2C register bank
package i2c_reg_bank_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_PTR, ST_DATA} state_t;

   localparam int REG_CTRL   = 0;
   localparam int REG_LED    = 1;
   localparam int REG_STATUS = 4;

   // Bits needed to index n items, never less than one so vectors stay legal
   function automatic int idx_width(input int n);
      int w;
      for (w = 1; (1 << w) < n; w++) begin
      end
      return w;
   endfunction

endpackage

// File: rtl/i2c_reg_bank_byte_sel.sv
// i2c_reg_bank_byte_sel: selects one little-endian byte lane of a register word
module i2c_reg_bank_byte_sel #(
   parameter int REG_BYTES = 2,
   parameter int BW        = 1
) (
   input  logic [8*REG_BYTES-1:0] word,
   input  logic [BW-1:0]          idx,
   output logic [7:0]             lane
);

   // Lanes past the end of the word read as zero
   always_comb lane = (int'(idx) < REG_BYTES) ? word[8*idx +: 8] : 8'h00;

endmodule

// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank: pointer-addressed register file behind the i2c_slave byte streams
module i2c_reg_bank
   import i2c_reg_bank_pkg::*;
#(
   parameter int                              NUM_REGS    = 8,
   parameter int                              REG_BYTES   = 2,
   parameter logic [NUM_REGS-1:0]             WRITE_MASK  = NUM_REGS'('h0F),
   parameter logic [NUM_REGS*8*REG_BYTES-1:0] RESET_VALUE = '0
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              bus_addressed,
   input  logic [7:0]                        rx_tdata,
   input  logic                              rx_tvalid,
   output logic                              rx_tready,
   output logic [7:0]                        tx_tdata,
   output logic                              tx_tvalid,
   input  logic                              tx_tready,
   output logic [NUM_REGS*8*REG_BYTES-1:0]   reg_q,
   input  logic [NUM_REGS*8*REG_BYTES-1:0]   status_i,
   output logic [NUM_REGS-1:0]               wr_strobe,
   output logic [NUM_REGS-1:0]               rd_strobe
);

   localparam int RW = 8 * REG_BYTES;
   localparam int PW = idx_width(NUM_REGS);
   localparam int BW = idx_width(REG_BYTES);

   state_t        state;
   logic [PW-1:0] ptr, ptr_next, ptr_load;
   logic [BW-1:0] byte_idx;
   logic [RW-1:0] staging, merged, snapshot, live;
   logic [RW-1:0] regs [NUM_REGS];
   logic          addr_q;

   wire rise    = bus_addressed & ~addr_q;
   wire rx_fire = rx_tvalid & rx_tready;
   wire tx_fire = tx_tvalid & tx_tready;
   wire last    = byte_idx == BW'(REG_BYTES - 1);

   // Pointer wrap, pointer-byte folding, staging merge and the word a snapshot would capture
   always_comb begin
      ptr_next = (ptr == PW'(NUM_REGS - 1)) ? '0 : ptr + 1'b1;
      ptr_load = (int'(rx_tdata[PW-1:0]) >= NUM_REGS) ? rx_tdata[PW-1:0] - PW'(NUM_REGS) : rx_tdata[PW-1:0];
      merged = staging;
      merged[8*byte_idx +: 8] = rx_tdata;
      live = WRITE_MASK[ptr] ? regs[ptr] : status_i[RW*ptr +: RW];
   end

   // Flat register image; read-only slots show zero
   always_comb begin
      reg_q = '0;
      for (int r = 0; r < NUM_REGS; r++) reg_q[r*RW +: RW] = WRITE_MASK[r] ? regs[r] : '0;
   end

   // Transaction sequencing: new-transaction restart, pointer load, atomic commits, snapshot reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         byte_idx  <= '0;
         staging   <= '0;
         snapshot  <= '0;
         addr_q    <= 1'b0;
         rx_tready <= 1'b0;
         tx_tvalid <= 1'b0;
         wr_strobe <= '0;
         rd_strobe <= '0;
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= WRITE_MASK[r] ? RESET_VALUE[r*RW +: RW] : '0;
      end else begin
         addr_q    <= bus_addressed;
         rx_tready <= 1'b1;
         wr_strobe <= '0;
         rd_strobe <= '0;
         if (rise) begin
            state     <= ST_PTR;
            byte_idx  <= '0;
            staging   <= '0;
            tx_tvalid <= 1'b0;
         end else if (rx_fire && state != ST_IDLE) begin
            tx_tvalid <= 1'b0;
            if (state == ST_PTR) begin
               state    <= ST_DATA;
               ptr      <= ptr_load;
               byte_idx <= '0;
            end else if (last) begin
               if (WRITE_MASK[ptr]) begin
                  regs[ptr]      <= merged;
                  wr_strobe[ptr] <= 1'b1;
               end
               ptr      <= ptr_next;
               byte_idx <= '0;
               staging  <= '0;
            end else begin
               staging  <= merged;
               byte_idx <= byte_idx + 1'b1;
            end
         end else if (tx_fire) begin
            if (last) begin
               ptr       <= ptr_next;
               byte_idx  <= '0;
               tx_tvalid <= 1'b0;
            end else begin
               byte_idx <= byte_idx + 1'b1;
            end
         end else if (!tx_tvalid && state != ST_IDLE && byte_idx == '0) begin
            snapshot       <= live;
            rd_strobe[ptr] <= 1'b1;
            tx_tvalid      <= 1'b1;
         end
      end
   end

   i2c_reg_bank_byte_sel #(.REG_BYTES(REG_BYTES), .BW(BW)) u_byte_sel (
      .word (snapshot),
      .idx  (byte_idx),
      .lane (tx_tdata)
   );

endmodule
